// File: rtl/fc_pkg.sv
// Shared types for the fully-connected accumulate/write path: fixed-point widths,
// FSM encoding and the round-toward-minus-infinity saturating narrowing helper.
package fc_pkg;

    localparam int unsigned FC_DW    = 16;
    localparam int unsigned FC_FRAC  = 8;
    localparam int unsigned FC_ACC_W = 40;

    typedef logic signed [FC_DW-1:0]    act_t;
    typedef logic signed [2*FC_DW-1:0]  prod_t;
    typedef logic signed [FC_ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        WRITE
    } fsm_e;

    localparam act_t ACT_MAX = {1'b0, {(FC_DW-1){1'b1}}};
    localparam act_t ACT_MIN = {1'b1, {(FC_DW-1){1'b0}}};

    // Drops FRAC bits with an arithmetic shift (floor), then clamps to the act_t range.
    function automatic act_t sat_shift(input acc_t a);
        acc_t s;
        s = a >>> FC_FRAC;
        if (s > acc_t'(ACT_MAX)) begin
            return ACT_MAX;
        end
        if (s < acc_t'(ACT_MIN)) begin
            return ACT_MIN;
        end
        return act_t'(s);
    endfunction

endpackage

// File: rtl/fc_acc_lane.sv
// One MAC output lane: accumulates products, folds in the aligned bias on the
// closing beat and presents the narrowed, saturated result.
module fc_acc_lane
    import fc_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  beat_i,
    input  logic  first_i,
    input  logic  bias_en_i,
    input  prod_t psum_i,
    input  act_t  bias_i,
    output act_t  data_o
);

    acc_t acc_q;
    acc_t acc_d;
    acc_t base;
    acc_t bias_ext;

    // A first beat restarts from zero, so the same adder serves load and accumulate.
    always_comb begin
        base     = first_i ? '0 : acc_q;
        bias_ext = bias_en_i ? (acc_t'(bias_i) <<< FC_FRAC) : '0;
        acc_d    = acc_q;
        if (beat_i) begin
            acc_d = base + acc_t'(psum_i) + bias_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign data_o = sat_shift(acc_q);

endmodule

// File: rtl/fc_accum_writer.sv
// Consumer of the fc_scheduler product stream: counts beats per neuron group, closes
// each group with its bias and writes one N_KERNELS-wide output vector per group.
module fc_accum_writer
    import fc_pkg::*;
#(
    parameter int unsigned N_KERNELS = 8,
    parameter int unsigned FAN_IN    = 784,
    parameter int unsigned N_GROUPS  = 8,
    parameter int unsigned OUT_ADDR  = 3,
    parameter int unsigned DW        = FC_DW,
    parameter int unsigned FRAC      = FC_FRAC,
    parameter int unsigned ACC_W     = FC_ACC_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      forward,
    input  logic                      valid_i,
    input  logic                      has_bias,
    input  logic [N_KERNELS*2*DW-1:0] psum_i,
    input  logic [N_KERNELS*DW-1:0]   bias_i,
    output logic                      wr_en,
    output logic [OUT_ADDR-1:0]       wr_addr,
    output logic [N_KERNELS*DW-1:0]   wr_data,
    output logic                      busy,
    output logic                      done,
    output logic                      seq_err
);

    localparam int unsigned BCW = (FAN_IN > 1) ? $clog2(FAN_IN) : 1;
    localparam logic [BCW-1:0]      LAST_BEAT = BCW'(FAN_IN - 1);
    localparam logic [OUT_ADDR-1:0] LAST_GRP  = OUT_ADDR'(N_GROUPS - 1);

    if (DW != FC_DW || FRAC != FC_FRAC || ACC_W != FC_ACC_W || (1 << OUT_ADDR) < N_GROUPS) begin : g_bad_cfg
        $error("fc_accum_writer: DW/FRAC/ACC_W must match fc_pkg and OUT_ADDR must cover N_GROUPS");
    end

    fsm_e                state_q, state_d;
    logic [BCW-1:0]      beat_cnt_q, beat_cnt_d;
    logic [OUT_ADDR-1:0] grp_cnt_q, grp_cnt_d;
    logic                busy_q, busy_d;
    logic                seq_err_q, seq_err_d;

    logic           accept;
    logic [BCW-1:0] beat_idx;
    logic           is_last_idx;
    logic           last_beat;
    logic           first_beat;
    logic           bias_en;
    logic           grp_last;
    act_t           lane_data [N_KERNELS];

    // Outside ACCUM the incoming beat is always beat 0 of a fresh group (this covers
    // the beat accepted during WRITE that keeps back-to-back groups bubble-free).
    always_comb begin
        accept      = valid_i & forward;
        beat_idx    = (state_q == ACCUM) ? beat_cnt_q : '0;
        is_last_idx = (beat_idx == LAST_BEAT);
        last_beat   = accept & is_last_idx;
        first_beat  = (state_q != ACCUM);
        bias_en     = last_beat & has_bias;
        grp_last    = (grp_cnt_q == LAST_GRP);
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        grp_cnt_d  = grp_cnt_q;
        busy_d     = busy_q;
        seq_err_d  = seq_err_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = last_beat ? WRITE : ACCUM;
                end
            end
            ACCUM: begin
                if (last_beat) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                grp_cnt_d = grp_last ? '0 : grp_cnt_q + OUT_ADDR'(1);
                if (accept) begin
                    state_d = last_beat ? WRITE : ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            beat_cnt_d = last_beat ? '0 : beat_idx + BCW'(1);
        end

        if (accept) begin
            busy_d = 1'b1;
        end else if (state_q == WRITE && grp_last) begin
            busy_d = 1'b0;
        end

        if (accept && (has_bias != is_last_idx)) begin
            seq_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            grp_cnt_q  <= '0;
            busy_q     <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            grp_cnt_q  <= grp_cnt_d;
            busy_q     <= busy_d;
            seq_err_q  <= seq_err_d;
        end
    end

    for (genvar k = 0; k < N_KERNELS; k++) begin : g_lane
        fc_acc_lane u_lane (
            .clk       (clk),
            .rst_n     (rst),
            .beat_i    (accept),
            .first_i   (first_beat),
            .bias_en_i (bias_en),
            .psum_i    (psum_i[k*2*DW +: 2*DW]),
            .bias_i    (bias_i[k*DW +: DW]),
            .data_o    (lane_data[k])
        );
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        done    = 1'b0;
        if (state_q == WRITE) begin
            wr_en   = 1'b1;
            wr_addr = grp_cnt_q;
            done    = grp_last;
            for (int unsigned k = 0; k < N_KERNELS; k++) begin
                wr_data[k*DW +: DW] = lane_data[k];
            end
        end
    end

    assign busy    = busy_q;
    assign seq_err = seq_err_q;

endmodule

// File: tb/tb_fc_accum_writer.sv
// Scoreboard bench for fc_accum_writer: directed groups push expected writes,
// a negedge monitor pops and compares address, data, done and write cycle.
module tb_fc_accum_writer;

    localparam int unsigned NK = 4;
    localparam int unsigned FI = 4;
    localparam int unsigned NG = 2;
    localparam int unsigned OA = 3;
    localparam int unsigned DW = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               forward = 1'b0;
    logic               valid_i = 1'b0;
    logic               has_bias = 1'b0;
    logic [NK*2*DW-1:0] psum_i = '0;
    logic [NK*DW-1:0]   bias_i = '0;
    logic               wr_en;
    logic [OA-1:0]      wr_addr;
    logic [NK*DW-1:0]   wr_data;
    logic               busy;
    logic               done;
    logic               seq_err;

    fc_accum_writer #(
        .N_KERNELS (NK),
        .FAN_IN    (FI),
        .N_GROUPS  (NG),
        .OUT_ADDR  (OA)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .forward  (forward),
        .valid_i  (valid_i),
        .has_bias (has_bias),
        .psum_i   (psum_i),
        .bias_i   (bias_i),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .seq_err  (seq_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OA-1:0]    addr;
        logic [NK*DW-1:0] data;
        logic             done;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && wr_en) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %h, expected no write (t=%0t)",
                         wr_addr, wr_data, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e.addr));
                check("wr_data", 64'(wr_data), 64'(e.data));
                check("done", 64'(done), 64'(e.done));
                check("write_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    function automatic logic [NK*2*DW-1:0] rep32(input logic [31:0] v);
        logic [NK*2*DW-1:0] r;
        for (int k = 0; k < NK; k++) r[k*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [NK*DW-1:0] rep16(input logic [15:0] v);
        logic [NK*DW-1:0] r;
        for (int k = 0; k < NK; k++) r[k*16 +: 16] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [NK*2*DW-1:0] pv, input logic [NK*DW-1:0] bv, input logic hb);
        forward  = 1'b1;
        valid_i  = 1'b1;
        has_bias = hb;
        psum_i   = pv;
        bias_i   = bv;
        tick();
        valid_i  = 1'b0;
        has_bias = 1'b0;
    endtask

    // Drives FI beats; the expected write is queued for the cycle right after the last beat.
    task automatic run_group(input logic [NK*2*DW-1:0] pv, input logic [NK*DW-1:0] bv,
                             input logic [3:0] hbmask, input bit gaps, input int pause_at,
                             input logic [NK*DW-1:0] exp_data, input logic [OA-1:0] exp_addr,
                             input logic exp_done);
        for (int b = 0; b < FI; b++) begin
            if (gaps) begin
                int n;
                n = int'($urandom_range(0, 3));
                repeat (n) tick();
            end
            if (b == pause_at) begin
                forward  = 1'b0;
                valid_i  = 1'b1;
                has_bias = 1'b1;
                psum_i   = '1;
                bias_i   = '1;
                repeat (5) tick();
                valid_i  = 1'b0;
                has_bias = 1'b0;
                forward  = 1'b1;
            end
            beat(pv, bv, hbmask[b]);
            if (b == FI - 1) begin
                exp_t e;
                e.addr = exp_addr;
                e.data = exp_data;
                e.done = exp_done;
                e.cyc  = cyc;
                sb.push_back(e);
            end
        end
    endtask

    localparam logic [31:0] P_ONE = 32'h0001_0000;
    localparam logic [31:0] P_TWO = 32'h0002_0000;
    localparam logic [15:0] B_HALF = 16'h0080;

    initial begin
        #2 rst = 1'b0;
        #1;
        check("reset_wr_en", 64'(wr_en), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_seq_err", 64'(seq_err), 64'd0);
        check("reset_wr_data", 64'(wr_data), 64'd0);
        check("reset_wr_addr", 64'(wr_addr), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // 1: smoke, 4 x 1.0 + 0.5 = 4.5
        run_group(rep32(P_ONE), rep16(B_HALF), 4'b1000, 0, -1, rep16(16'h0480), 3'd0, 1'b0);
        tick();
        check("busy_between_groups", 64'(busy), 64'd1);
        run_group(rep32(P_ONE), rep16(B_HALF), 4'b1000, 0, -1, rep16(16'h0480), 3'd1, 1'b1);
        tick();
        check("busy_after_done", 64'(busy), 64'd0);

        // 2: saturation and floor; lanes {+1, -1, -max, +max}
        run_group({32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF}, '0, 4'b1000, 0, -1,
                  {16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF}, 3'd0, 1'b0);
        run_group({32'h0000_0000, 32'h0000_0040, 32'hFFFF_8000, 32'h0001_0000},
                  {16'h8000, 16'h0000, 16'h0100, 16'hFF80}, 4'b1000, 0, -1,
                  {16'h8000, 16'h0001, 16'hFF00, 16'h0380}, 3'd1, 1'b1);
        tick();

        // 3: back-to-back, next group's beat 0 lands in WRITE
        run_group(rep32(P_ONE), rep16(B_HALF), 4'b1000, 0, -1, rep16(16'h0480), 3'd0, 1'b0);
        check("busy_in_write", 64'(busy), 64'd1);
        run_group(rep32(P_TWO), '0, 4'b1000, 0, -1, rep16(16'h0800), 3'd1, 1'b1);
        tick();

        // 4: random gaps and a 5-cycle forward=0 stall mid-group
        run_group(rep32(P_ONE), rep16(B_HALF), 4'b1000, 1, 2, rep16(16'h0480), 3'd0, 1'b0);
        run_group(rep32(P_TWO), '0, 4'b1000, 1, -1, rep16(16'h0800), 3'd1, 1'b1);
        tick();
        check("seq_err_clean", 64'(seq_err), 64'd0);

        // 5: stray has_bias on beat 1 is ignored; missing has_bias closes without bias
        run_group(rep32(P_ONE), rep16(B_HALF), 4'b1010, 0, -1, rep16(16'h0480), 3'd0, 1'b0);
        check("seq_err_early_bias", 64'(seq_err), 64'd1);
        run_group(rep32(P_ONE), rep16(B_HALF), 4'b0000, 0, -1, rep16(16'h0400), 3'd1, 1'b1);
        repeat (3) tick();
        check("seq_err_sticky", 64'(seq_err), 64'd1);

        // 6: reset at beat 2 of the second group discards the partial sum and group index
        run_group(rep32(P_ONE), rep16(B_HALF), 4'b1000, 0, -1, rep16(16'h0480), 3'd0, 1'b0);
        tick();
        beat(rep32(32'h0010_0000), rep16(B_HALF), 1'b0);
        beat(rep32(32'h0010_0000), rep16(B_HALF), 1'b0);
        check("busy_mid_group", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_seq_err", 64'(seq_err), 64'd0);
        check("async_rst_wr_en", 64'(wr_en), 64'd0);
        check("async_rst_wr_data", 64'(wr_data), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        run_group(rep32(P_ONE), rep16(B_HALF), 4'b1000, 0, -1, rep16(16'h0480), 3'd0, 1'b0);
        run_group(rep32(P_TWO), '0, 4'b1000, 0, -1, rep16(16'h0800), 3'd1, 1'b1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
